// File: rtl/digitron_display_arbiter.sv
// Purpose: round-robin arbiter that shares one two-digit display among four requesters.
//          A granted source keeps the display for at least DWELL cycles unless it drops its request.
// Latency: Req seen at an edge in IDLE gives Grant/Result on that edge. Result tracks live data one cycle late.
// Backpressure: none. Waiting requesters stay pending until the holder releases or its dwell expires.
//          A one-cycle RELEASE gap separates successive grants.
// Ports:
//   CLK, RSTn     - clock; asynchronous active-low reset
//   Req[3:0]      - level-sensitive requests
//   Data_In[31:0] - per-source data; source i is Data_In[8i+7:8i]
//   Grant[3:0]    - one-hot grant or zero (registered)
//   Src[1:0]      - current or last granted index (registered)
//   Result[7:0]   - value forwarded to the display driver (registered)
//   Busy          - high when not IDLE (registered)
module digitron_display_arbiter #(
    parameter logic [15:0] DWELL    = 16'd50000,
    parameter logic [7:0]  IDLE_VAL = 8'h00
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [3:0]  Req,
    input  logic [31:0] Data_In,
    output logic [3:0]  Grant,
    output logic [1:0]  Src,
    output logic [7:0]  Result,
    output logic        Busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] DWELL_M1 = DWELL - 16'd1;

    state_t      state, state_n;
    logic [1:0]  last, last_n;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  grant_n;
    logic [1:0]  src_n;
    logic [7:0]  result_n;
    logic        busy_n;

    logic [1:0]  win;
    logic [1:0]  cand;
    logic        any_req;
    logic        other_req;
    logic        dwell_done;

    // Round-robin pick. The search runs from farthest to nearest so the
    // nearest requester after last overwrites the others. The previous
    // holder is the fallback, so it only wins again when nobody else asks.
    always_comb begin
        win  = last;
        cand = last;
        for (int k = 3; k >= 1; k--) begin
            cand = last + 2'(k);
            if (Req[cand]) begin
                win = cand;
            end
        end
    end

    assign any_req    = |Req;
    assign other_req  = |(Req & ~(4'b0001 << Src));
    assign dwell_done = (cnt == DWELL_M1);

    always_comb begin
        state_n  = state;
        last_n   = last;
        cnt_n    = cnt;
        grant_n  = Grant;
        src_n    = Src;
        result_n = Result;
        case (state)
            S_IDLE, S_RELEASE: begin
                grant_n = 4'b0000;
                if (any_req) begin
                    state_n  = S_GRANT;
                    grant_n  = 4'b0001 << win;
                    src_n    = win;
                    last_n   = win;
                    cnt_n    = 16'd0;
                    result_n = Data_In[8*win +: 8];
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GRANT: begin
                // A voluntary drop takes priority. Pre-emption only
                // happens once the dwell has fully elapsed.
                if (!Req[Src] || (dwell_done && other_req)) begin
                    state_n = S_RELEASE;
                    grant_n = 4'b0000;
                end else begin
                    if (!dwell_done) begin
                        cnt_n = cnt + 16'd1;
                    end
                    result_n = Data_In[8*Src +: 8];
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = 4'b0000;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= S_IDLE;
            last   <= 2'd3;
            cnt    <= 16'd0;
            Grant  <= 4'b0000;
            Src    <= 2'd0;
            Result <= IDLE_VAL;
            Busy   <= 1'b0;
        end else begin
            state  <= state_n;
            last   <= last_n;
            cnt    <= cnt_n;
            Grant  <= grant_n;
            Src    <= src_n;
            Result <= result_n;
            Busy   <= busy_n;
        end
    end

endmodule

// File: tb/tb_digitron_display_arbiter.sv
// Bench for digitron_display_arbiter with DWELL=4 and a non-zero IDLE_VAL.
// A behavioural model tracks the holder and how long it has held the display.
// Directed scenarios run first, then a randomized request/data run.
module tb_digitron_display_arbiter;

    localparam int          DW   = 4;
    localparam logic [7:0]  IVAL = 8'hA5;

    logic        CLK;
    logic        RSTn;
    logic [3:0]  Req;
    logic [31:0] Data_In;
    logic [3:0]  Grant;
    logic [1:0]  Src;
    logic [7:0]  Result;
    logic        Busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int         m_holder;   // -1 when nobody holds the display
    int         m_held;     // cycles the current holder has shown
    bit         m_gap;      // one-cycle gap after a release
    int         m_last;
    int         m_src;
    logic [7:0] m_result;

    digitron_display_arbiter #(.DWELL(16'(DW)), .IDLE_VAL(IVAL)) dut (
        .CLK(CLK), .RSTn(RSTn), .Req(Req), .Data_In(Data_In),
        .Grant(Grant), .Src(Src), .Result(Result), .Busy(Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_held   = 0;
        m_gap    = 1'b0;
        m_last   = 3;
        m_src    = 0;
        m_result = IVAL;
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step();
        if (m_holder >= 0) begin
            logic [3:0] others;
            others = Req & ~(4'b0001 << m_holder);
            if (!Req[m_holder] || (m_held >= DW && others != 4'b0000)) begin
                m_holder = -1;
                m_gap    = 1'b1;
            end else begin
                m_held++;
                m_result = Data_In[8*m_holder +: 8];
            end
        end else begin
            m_gap = 1'b0;
            if (Req != 4'b0000) begin
                m_holder = rr_pick(m_last, Req);
                m_last   = m_holder;
                m_src    = m_holder;
                m_held   = 1;
                m_result = Data_In[8*m_holder +: 8];
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eg;
        eg = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
        chk({tag, ".grant"},  32'(Grant),  32'(eg));
        chk({tag, ".src"},    32'(Src),    32'(m_src));
        chk({tag, ".result"}, 32'(Result), 32'(m_result));
        chk({tag, ".busy"},   32'(Busy),   32'((m_holder >= 0) || m_gap));
    endtask

    // One clock: the model consumes the inputs seen at the edge, and the
    // DUT outputs are sampled 1 time unit later.
    task automatic tick(input string tag);
        @(posedge CLK);
        model_step();
        #1;
        check_model(tag);
    endtask

    // Called 1 time unit after an edge. Reset is asserted and checked
    // between edges, then released before the next edge.
    task automatic pulse_reset(input logic [3:0] req_after);
        #1;
        RSTn = 1'b0;
        #1;
        chk("rst.grant",  32'(Grant),  32'h0);
        chk("rst.src",    32'(Src),    32'h0);
        chk("rst.result", 32'(Result), 32'(IVAL));
        chk("rst.busy",   32'(Busy),   32'h0);
        model_reset();
        Req = req_after;
        #1;
        RSTn = 1'b1;
    endtask

    logic [3:0] exp_g;

    initial begin
        RSTn    = 1'b0;
        Req     = 4'b0000;
        Data_In = 32'h0;
        model_reset();
        #12;
        RSTn = 1'b1;
        repeat (3) tick("idle");

        // Reset values with no clock edge involved.
        pulse_reset(4'b0000);
        tick("idle2");

        // Single requester, live data tracking and an indefinite hold.
        Req     = 4'b0100;
        Data_In = 32'h0037_0000;
        tick("single");
        chk("single.grant",  32'(Grant),  32'h4);
        chk("single.src",    32'(Src),    32'h2);
        chk("single.result", 32'(Result), 32'h37);
        chk("single.busy",   32'(Busy),   32'h1);
        Data_In = 32'h1152_3344;
        tick("single_data");
        chk("single.newdata", 32'(Result), 32'h52);
        repeat (110) tick("single_hold");
        chk("single.persist", 32'(Grant), 32'h4);

        // Round robin between two continuous requesters.
        pulse_reset(4'b0011);
        Data_In = 32'h0000_2211;
        for (int i = 0; i < 11; i++) begin
            tick("rr");
            if (i < 4)       exp_g = 4'b0001;
            else if (i == 4) exp_g = 4'b0000;
            else if (i < 9)  exp_g = 4'b0010;
            else if (i == 9) exp_g = 4'b0000;
            else             exp_g = 4'b0001;
            chk($sformatf("rr.seq%0d", i), 32'(Grant), 32'(exp_g));
        end

        // Voluntary early release by requester 1.
        pulse_reset(4'b0010);
        Data_In = 32'h0000_6600;
        tick("vol");
        tick("vol");
        Req = 4'b0000;
        tick("vol_rel");
        chk("vol.gap_grant", 32'(Grant), 32'h0);
        chk("vol.gap_busy",  32'(Busy),  32'h1);
        tick("vol_idle");
        chk("vol.idle_busy",   32'(Busy),   32'h0);
        chk("vol.idle_result", 32'(Result), 32'h66);

        // Fairness with all four requesting.
        pulse_reset(4'b1111);
        Data_In = 32'h4433_2211;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < DW; c++) begin
                tick("all");
                chk($sformatf("all.g%0d_c%0d", g, c), 32'(Grant), 32'(4'b0001 << (g % 4)));
            end
            if (g < 4) begin
                tick("all_gap");
                chk($sformatf("all.gap%0d", g), 32'(Grant), 32'h0);
            end
        end

        // Reset in the middle of a grant to requester 3.
        pulse_reset(4'b1000);
        repeat (2) tick("mid");
        chk("mid.held3", 32'(Grant), 32'h8);
        pulse_reset(4'b1001);
        tick("mid_after");
        chk("mid.first0", 32'(Grant), 32'h1);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) Req = 4'($urandom_range(0, 15));
            Data_In = $urandom;
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
